// File: rtl/otter_mmio_pkg.sv
// Shared definitions for the OTTER memory-mapped IO block: address map, TX FSM states
// and status register layout.
package otter_mmio_pkg;

    localparam logic [31:0] ADDR_SWITCHES  = 32'h1100_0000;
    localparam logic [31:0] ADDR_LEDS      = 32'h1100_0020;
    localparam logic [31:0] ADDR_UART_TX   = 32'h1100_0040;
    localparam logic [31:0] ADDR_UART_STAT = 32'h1100_0044;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    // The status register only has four bits for the FIFO level, so larger levels clip at 15.
    function automatic logic [3:0] sat_cnt4(input logic [31:0] cnt);
        if (cnt > 32'd15) begin
            return 4'd15;
        end else begin
            return cnt[3:0];
        end
    endfunction

endpackage

// File: rtl/otter_uart_tx_core.sv
// 8N1 serial transmitter: one start bit, eight data bits LSB first, one stop bit,
// each held for DIV clocks. Accepts a byte through a valid/ready handshake.
module otter_uart_tx_core
    import otter_mmio_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_txd,
    output logic       o_busy
);

    localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    tx_state_t     r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_txd;
    logic          w_bit_end;

    assign w_bit_end = (r_baud == BAUD_LAST);
    // Taking a byte on the last stop-bit clock lets the next start bit follow with no idle gap.
    assign o_ready   = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
    assign o_busy    = (r_state != IDLE);
    assign o_txd     = r_txd;

    // Frame sequencer: baud counter restarts on every state entry, txd is set at the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    if (i_valid) begin
                        r_shift <= i_data;
                        r_state <= START;
                        r_txd   <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_baud  <= '0;
                        r_bit   <= 3'd0;
                        r_txd   <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (i_valid) begin
                            r_shift <= i_data;
                            r_state <= START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_baud  <= '0;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/otter_mmio_uart.sv
// OTTER IO peripheral: switch input, LED register and a FIFO-buffered UART transmitter,
// decoded on the full 32-bit IO address.
module otter_mmio_uart
    import otter_mmio_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IO_WR,
    input  logic [31:0] IO_ADDR,
    input  logic [31:0] IO_DATA,
    input  logic [15:0] SWITCHES,
    output logic [31:0] IO_IN,
    output logic [15:0] LEDS,
    output logic        UART_TXD,
    output logic        TX_IRQ
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic [15:0]   r_leds;

    logic          w_sel_leds;
    logic          w_sel_tx;
    logic          w_sel_stat;
    logic          w_full;
    logic          w_empty;
    logic          w_core_ready;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_busy;
    logic          w_txd;
    logic [7:0]    w_stat;
    logic          w_unused;

    assign w_sel_leds = IO_WR && (IO_ADDR == ADDR_LEDS);
    assign w_sel_tx   = IO_WR && (IO_ADDR == ADDR_UART_TX);
    assign w_sel_stat = IO_WR && (IO_ADDR == ADDR_UART_STAT);

    assign w_full  = (r_cnt == CNT_FULL);
    assign w_empty = (r_cnt == '0);
    assign w_pop   = w_core_ready && !w_empty;
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign w_push  = w_sel_tx && (!w_full || w_pop);
    assign w_drop  = w_sel_tx && w_full && !w_pop;

    assign w_unused = ^IO_DATA[31:16];

    otter_uart_tx_core #(
        .DIV (DIV)
    ) u_tx_core (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_valid (!w_empty),
        .i_data  (r_mem[r_rd_ptr]),
        .o_ready (w_core_ready),
        .o_txd   (w_txd),
        .o_busy  (w_busy)
    );

    // LED register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_leds <= 16'd0;
        end else if (w_sel_leds) begin
            r_leds <= IO_DATA[15:0];
        end
    end

    // FIFO storage; stale contents are harmless because reset clears the pointers and count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= IO_DATA[7:0];
        end
    end

    // FIFO pointers, fill level and the sticky overflow flag (a set beats a clearing write).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_sel_stat) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign w_stat = {sat_cnt4(32'(r_cnt)), r_ovf, w_busy, w_empty, w_full};

    // Read mux: combinational on the address so the memory can register it directly.
    always_comb begin
        IO_IN = 32'd0;
        case (IO_ADDR)
            ADDR_SWITCHES:  IO_IN = {16'd0, SWITCHES};
            ADDR_LEDS:      IO_IN = {16'd0, r_leds};
            ADDR_UART_STAT: IO_IN = {24'd0, w_stat};
            default:        IO_IN = 32'd0;
        endcase
    end

    assign LEDS     = r_leds;
    assign UART_TXD = w_txd;
    assign TX_IRQ   = w_empty && !w_busy;

endmodule

// File: tb/tb_otter_mmio_uart.sv
// Bench for otter_mmio_uart: register map table, frame timing sequences and a random run
// compared every cycle against a queue-based reference model.
module tb_otter_mmio_uart;
    import otter_mmio_pkg::*;

    localparam int DIV   = 10;
    localparam int FRAME = 10 * DIV;
    localparam int DEPTH = 8;
    localparam int LMAX  = 1200;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IO_WR = 1'b0;
    logic [31:0] IO_ADDR = 32'd0;
    logic [31:0] IO_DATA = 32'd0;
    logic [15:0] SWITCHES = 16'd0;
    logic [31:0] IO_IN;
    logic [15:0] LEDS;
    logic        UART_TXD;
    logic        TX_IRQ;

    otter_mmio_uart #(.CLK_HZ(100), .BAUD(10), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .IO_WR(IO_WR), .IO_ADDR(IO_ADDR), .IO_DATA(IO_DATA),
        .SWITCHES(SWITCHES), .IO_IN(IO_IN), .LEDS(LEDS), .UART_TXD(UART_TXD), .TX_IRQ(TX_IRQ)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: LED value, FIFO as a queue, sticky overflow, position inside current frame.
    logic [15:0] m_leds = 16'd0;
    logic [7:0]  m_q[$];
    logic        m_ovf = 1'b0;
    int          m_pos = -1;
    logic [7:0]  m_byte = 8'd0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] sw;
        logic [31:0] exp_rd;
        logic [15:0] exp_leds;
    } vec_t;

    vec_t        vecs[13];
    logic        line_a[LMAX];
    int          n_line;
    int          exp_line[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    logic [7:0]  burst_bytes[10];
    logic [31:0] rand_addrs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic fbit(input logic [7:0] b, input int j);
        int k;
        k = j / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    function automatic logic m_txd();
        if (m_pos < 0) return 1'b1;
        return fbit(m_byte, m_pos);
    endfunction

    function automatic logic [31:0] m_stat();
        int n;
        logic [3:0] c;
        n = m_q.size();
        c = (n > 15) ? 4'd15 : 4'(n);
        return {24'd0, c, m_ovf, (m_pos >= 0), (n == 0), (n == DEPTH)};
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] addr);
        if (addr == ADDR_SWITCHES)  return {16'd0, SWITCHES};
        if (addr == ADDR_LEDS)      return {16'd0, m_leds};
        if (addr == ADDR_UART_STAT) return m_stat();
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_leds = 16'd0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_pos  = -1;
        m_byte = 8'd0;
    endtask

    task automatic model_step(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        logic       pop;
        logic       set_ovf;
        logic [7:0] head;
        if (RST) begin
            model_reset();
            return;
        end
        pop     = (m_q.size() != 0) && (m_pos < 0 || m_pos == FRAME - 1);
        head    = pop ? m_q[0] : 8'd0;
        set_ovf = 1'b0;
        if (wr && addr == ADDR_UART_TX) begin
            if (m_q.size() < DEPTH || pop) m_q.push_back(data[7:0]);
            else set_ovf = 1'b1;
        end
        if (pop) begin
            void'(m_q.pop_front());
            m_byte = head;
            m_pos  = 0;
        end else if (m_pos >= 0) begin
            m_pos++;
            if (m_pos == FRAME) m_pos = -1;
        end
        if (set_ovf) m_ovf = 1'b1;
        else if (wr && addr == ADDR_UART_STAT) m_ovf = 1'b0;
        if (wr && addr == ADDR_LEDS) m_leds = data[15:0];
    endtask

    // One clock: drive at the falling edge, compare against the model, advance model, wait.
    task automatic tick(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rd, output logic txd);
        IO_WR = wr; IO_ADDR = addr; IO_DATA = data;
        #1;
        rd  = IO_IN;
        txd = UART_TXD;
        chk("model_txd", {31'd0, UART_TXD}, {31'd0, m_txd()});
        chk("model_irq", {31'd0, TX_IRQ}, {31'd0, (m_q.size() == 0 && m_pos < 0)});
        chk("model_leds", {16'd0, LEDS}, {16'd0, m_leds});
        chk("model_io_in", IO_IN, m_read(addr));
        model_step(wr, addr, data);
        @(negedge CLK);
    endtask

    task automatic rec_tick(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] rd);
        logic t;
        tick(wr, addr, data, rd, t);
        if (n_line < LMAX) begin
            line_a[n_line] = t;
            n_line++;
        end
    endtask

    task automatic idle(input int n);
        logic [31:0] rd;
        logic        t;
        for (int i = 0; i < n; i++) tick(1'b0, ADDR_UART_STAT, 32'd0, rd, t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        t;
        logic        irq_a[110];
        logic        line55[110];
        logic        busy55[110];
        int          s;
        int          mism;
        int          found;
        int          zeros;

        vecs[0]  = '{1'b0, ADDR_SWITCHES,   32'd0,         16'hA5C3, 32'h0000_A5C3, 16'h0000};
        vecs[1]  = '{1'b0, ADDR_LEDS,       32'd0,         16'hA5C3, 32'h0000_0000, 16'h0000};
        vecs[2]  = '{1'b0, ADDR_UART_STAT,  32'd0,         16'hA5C3, 32'h0000_0002, 16'h0000};
        vecs[3]  = '{1'b0, ADDR_UART_TX,    32'd0,         16'hA5C3, 32'h0000_0000, 16'h0000};
        vecs[4]  = '{1'b1, ADDR_LEDS,       32'hDEAD_BEEF, 16'hA5C3, 32'h0000_0000, 16'hBEEF};
        vecs[5]  = '{1'b0, ADDR_LEDS,       32'd0,         16'hA5C3, 32'h0000_BEEF, 16'hBEEF};
        vecs[6]  = '{1'b1, 32'h1100_0060,   32'h0000_1234, 16'hA5C3, 32'h0000_0000, 16'hBEEF};
        vecs[7]  = '{1'b0, 32'h1100_0060,   32'd0,         16'hA5C3, 32'h0000_0000, 16'hBEEF};
        vecs[8]  = '{1'b0, 32'h1100_0024,   32'd0,         16'hA5C3, 32'h0000_0000, 16'hBEEF};
        vecs[9]  = '{1'b0, ADDR_SWITCHES,   32'd0,         16'h0001, 32'h0000_0001, 16'hBEEF};
        vecs[10] = '{1'b1, ADDR_SWITCHES,   32'h0000_FFFF, 16'h7E81, 32'h0000_7E81, 16'hBEEF};
        vecs[11] = '{1'b1, ADDR_UART_STAT,  32'd0,         16'h7E81, 32'h0000_0002, 16'hBEEF};
        vecs[12] = '{1'b0, 32'h0100_0020,   32'd0,         16'h7E81, 32'h0000_0000, 16'hBEEF};

        for (int i = 0; i < 9; i++) burst_bytes[i] = 8'hA0 + 8'(i);
        burst_bytes[9] = 8'h3C;
        rand_addrs = '{ADDR_SWITCHES, ADDR_LEDS, ADDR_UART_TX, ADDR_UART_STAT,
                       32'h1100_0060, 32'h1100_0041, 32'h0000_0044};

        // Reset and register map
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        model_reset();
        RST = 1'b0;
        chk("rst_txd", {31'd0, UART_TXD}, 32'd1);
        chk("rst_irq", {31'd0, TX_IRQ}, 32'd1);
        chk("rst_leds", {16'd0, LEDS}, 32'd0);
        for (int i = 0; i < 13; i++) begin
            SWITCHES = vecs[i].sw;
            tick(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, t);
            chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_leds", i), {16'd0, LEDS}, {16'd0, vecs[i].exp_leds});
        end

        // Single 0x55 frame: every level exactly DIV clocks
        tick(1'b1, ADDR_UART_TX, 32'h0000_0055, rd, t);
        for (int k = 0; k < 104; k++) begin
            irq_a[k] = TX_IRQ;
            tick(1'b0, ADDR_UART_STAT, 32'd0, rd, t);
            line55[k] = t;
            busy55[k] = rd[STAT_BUSY];
        end
        chk("f55_pre_start", {31'd0, line55[0]}, 32'd1);
        mism = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (line55[1+i] !== 1'(exp_line[i / DIV])) mism++;
            if (busy55[1+i] !== 1'b1) mism++;
        end
        chk("f55_levels", mism, 32'd0);
        chk("f55_irq_in_stop", {31'd0, irq_a[100]}, 32'd0);
        chk("f55_irq_after", {31'd0, irq_a[101]}, 32'd1);
        chk("f55_line_after", {31'd0, line55[101]}, 32'd1);

        // Ten pushes back-to-back: one pops, eight queue, one overflows
        n_line = 0;
        for (int i = 0; i < 10; i++) rec_tick(1'b1, ADDR_UART_TX, 32'hFFFF_FF00 | 32'(8'hA0 + 8'(i)), rd);
        rec_tick(1'b0, ADDR_UART_STAT, 32'd0, rd);
        chk("burst_stat_ovf", rd, 32'h0000_008D);
        rec_tick(1'b1, ADDR_UART_STAT, 32'd0, rd);
        rec_tick(1'b0, ADDR_UART_STAT, 32'd0, rd);
        chk("burst_stat_clr", rd, 32'h0000_0085);
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            if (m_q.size() == DEPTH && m_pos == FRAME - 1) found = 1;
            else rec_tick(1'b0, ADDR_UART_STAT, 32'd0, rd);
        end
        chk("pop_sync_found", found, 32'd1);
        rec_tick(1'b1, ADDR_UART_TX, 32'h0000_003C, rd);
        rec_tick(1'b0, ADDR_UART_STAT, 32'd0, rd);
        chk("push_at_pop_stat", rd, 32'h0000_0085);
        for (int k = 0; k < 1100 && TX_IRQ !== 1'b1 && n_line < LMAX; k++)
            rec_tick(1'b0, ADDR_UART_STAT, 32'd0, rd);
        chk("burst_drained", {31'd0, TX_IRQ}, 32'd1);
        s = -1;
        for (int i = 0; i < n_line; i++) begin
            if (line_a[i] == 1'b0) begin
                s = i;
                break;
            end
        end
        chk("burst_first_start", s, 32'd2);
        for (int f = 0; f < 10; f++) begin
            mism = 0;
            for (int j = 0; j < FRAME; j++) begin
                if (s < 0 || s + f * FRAME + j >= n_line) mism++;
                else if (line_a[s + f * FRAME + j] !== fbit(burst_bytes[f], j)) mism++;
            end
            chk($sformatf("burst_frame%0d", f), mism, 32'd0);
        end
        chk("burst_len_no_gap", n_line, s + 10 * FRAME);

        // Random traffic against the model
        RST = 1'b1;
        tick(1'b0, ADDR_UART_STAT, 32'd0, rd, t);
        RST = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            int          r;
            logic        wr;
            logic [31:0] addr;
            SWITCHES = 16'($urandom);
            r    = $urandom_range(0, 15);
            wr   = 1'b0;
            addr = rand_addrs[$urandom_range(0, 6)];
            if (r < 3 && ((k % 500) < 150 || $urandom_range(0, 40) == 0)) begin
                wr = 1'b1; addr = ADDR_UART_TX;
            end else if (r == 3) begin
                wr = 1'b1; addr = ADDR_LEDS;
            end else if (r == 4 && $urandom_range(0, 7) == 0) begin
                wr = 1'b1; addr = ADDR_UART_STAT;
            end else if (r == 5) begin
                wr = 1'b1;
            end
            tick(wr, addr, $urandom, rd, t);
        end

        // Reset in the middle of the data bits
        RST = 1'b1;
        tick(1'b0, ADDR_UART_STAT, 32'd0, rd, t);
        RST = 1'b0;
        tick(1'b1, ADDR_UART_TX, 32'h0000_000F, rd, t);
        tick(1'b1, ADDR_UART_TX, 32'h0000_0033, rd, t);
        tick(1'b1, ADDR_UART_TX, 32'h0000_0077, rd, t);
        idle(40);
        RST = 1'b1;
        tick(1'b0, ADDR_UART_STAT, 32'd0, rd, t);
        RST = 1'b0;
        tick(1'b0, ADDR_UART_STAT, 32'd0, rd, t);
        chk("rst_mid_txd", {31'd0, t}, 32'd1);
        chk("rst_mid_stat", rd, 32'h0000_0002);
        zeros = 0;
        for (int k = 0; k < 150; k++) begin
            tick(1'b0, ADDR_UART_STAT, 32'd0, rd, t);
            if (t !== 1'b1) zeros++;
        end
        chk("rst_mid_no_bits", zeros, 32'd0);
        chk("rst_mid_irq", {31'd0, TX_IRQ}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
